// File: rtl/ram_req_ctrl_if.sv
// Command / response / RAM-side bundle for ram_req_ctrl.
// The slave modport is the controller's view. The master modport is the
// environment's view: the requester, the response consumer and the attached RAM.
interface ram_req_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  // Command channel
  logic                  req_valid;
  logic                  req_ready;
  logic [1:0]            req_op;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [ADDR_WIDTH:0]   req_len;
  logic [DATA_WIDTH-1:0] req_data;
  // Response channel
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  done;
  // RAM port
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  req_valid, req_op, req_addr, req_len, req_data, rsp_ready, ram_dout,
    output req_ready, rsp_valid, rsp_data, done, ram_addr, ram_we, ram_din
  );

  modport master (
    output req_valid, req_op, req_addr, req_len, req_data, rsp_ready, ram_dout,
    input  req_ready, rsp_valid, rsp_data, done, ram_addr, ram_we, ram_din
  );
endinterface

// File: rtl/ram_req_ctrl.sv
// Request front end for a synchronous single-port RAM with a 1-cycle read.
// It accepts read, write and burst-fill commands and drives the RAM ports from
// registers. Read data is returned over a valid/ready response channel.
// Write, fill and reserved commands finish with a one-cycle done pulse.
module ram_req_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic            clk,
  input  logic            rst,
  ram_req_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_RSP  = 3'd2,
    WR      = 3'd3,
    FILL    = 3'd4
  } state_t;

  localparam logic [1:0]            OP_READ  = 2'b00;
  localparam logic [1:0]            OP_WRITE = 2'b01;
  localparam logic [1:0]            OP_FILL  = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] ONE_A    = 1;

  state_t                state_q,     state_d;
  logic [ADDR_WIDTH-1:0] cnt_q,       cnt_d;
  logic                  rd_phase_q,  rd_phase_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,  ram_addr_d;
  logic                  ram_we_q,    ram_we_d;
  logic [DATA_WIDTH-1:0] ram_din_q,   ram_din_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic                  done_q,      done_d;

  // req_ready is the only output decoded combinationally from state.
  assign bus.req_ready = (state_q == IDLE);
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_we    = ram_we_q;
  assign bus.ram_din   = ram_din_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.done      = done_q;

  // Next-state and registered-output decode for the command FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rd_phase_d  = rd_phase_q;
    ram_addr_d  = ram_addr_q;
    ram_we_d    = ram_we_q;
    ram_din_d   = ram_din_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          case (bus.req_op)
            OP_READ: begin
              ram_addr_d = bus.req_addr;
              ram_we_d   = 1'b0;
              rd_phase_d = 1'b0;
              state_d    = RD_ADDR;
            end
            OP_WRITE: begin
              ram_addr_d = bus.req_addr;
              ram_din_d  = bus.req_data;
              ram_we_d   = 1'b1;
              state_d    = WR;
            end
            OP_FILL: begin
              if (bus.req_len == '0) begin
                done_d = 1'b1;
              end else begin
                ram_addr_d = bus.req_addr;
                ram_din_d  = bus.req_data;
                ram_we_d   = 1'b1;
                // A full-memory length has zero low bits, so the subtraction
                // wraps to 2^ADDR_WIDTH-1. That is still the correct remaining count.
                cnt_d      = bus.req_len[ADDR_WIDTH-1:0] - ONE_A;
                state_d    = FILL;
              end
            end
            default: begin
              done_d = 1'b1;
            end
          endcase
        end
      end

      RD_ADDR: begin
        // The first edge lets the RAM sample the address.
        // The second edge captures its output.
        if (!rd_phase_q) begin
          rd_phase_d = 1'b1;
        end else begin
          rsp_data_d  = bus.ram_dout;
          rsp_valid_d = 1'b1;
          state_d     = RD_RSP;
        end
      end

      RD_RSP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      WR: begin
        ram_we_d = 1'b0;
        done_d   = 1'b1;
        state_d  = IDLE;
      end

      FILL: begin
        if (cnt_q != '0) begin
          ram_addr_d = ram_addr_q + ONE_A;
          cnt_d      = cnt_q - ONE_A;
        end else begin
          ram_we_d = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  // Reset aborts any command at once; words already written stay in the RAM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rd_phase_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_we_q    <= 1'b0;
      ram_din_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rd_phase_q  <= rd_phase_d;
      ram_addr_q  <= ram_addr_d;
      ram_we_q    <= ram_we_d;
      ram_din_q   <= ram_din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_ram_req_ctrl.sv
// Bench for ram_req_ctrl: a behavioural 1-cycle-read RAM, directed command
// sequences and a queue of expected read data that is consumed on each response.
module tb_ram_req_ctrl;
  localparam int DW = 32;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ram_req_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  ram_req_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Attached RAM: synchronous write, 1-cycle registered read
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    bus.ram_dout <= mem[bus.ram_addr];
  end

  // Record every address written and every done pulse
  logic [AW-1:0] we_log[$];
  int            done_cnt = 0;
  always @(posedge clk) begin
    if (bus.ram_we) we_log.push_back(bus.ram_addr);
    if (bus.done)   done_cnt++;
  end

  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic drive_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                           input logic [AW:0] len, input logic [DW-1:0] data);
    int w;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_len   = len;
    bus.req_data  = data;
    w = 0;
    while (!bus.req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("accept_wait", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic take_rsp(input string tag);
    logic [DW-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'd0, 64'd1);
      return;
    end
    e = exp_q.pop_front();
    chk({tag, "_data"}, bus.rsp_data, e);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    chk({tag, "_rsp_clr"}, {63'd0, bus.rsp_valid}, 64'd0);
    chk({tag, "_idle"}, {63'd0, bus.req_ready}, 64'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] addr, input logic [DW-1:0] e, input string tag);
    int lat;
    exp_q.push_back(e);
    drive_cmd(2'b00, addr, '0, '0);
    wait_rsp(lat);
    chk({tag, "_lat"}, lat, 64'd2);
    take_rsp(tag);
  endtask

  task automatic do_write(input logic [AW-1:0] addr, input logic [DW-1:0] d, input string tag);
    int d0;
    d0 = done_cnt;
    drive_cmd(2'b01, addr, '0, d);
    chk({tag, "_we"}, {63'd0, bus.ram_we}, 64'd1);
    chk({tag, "_addr"}, bus.ram_addr, addr);
    chk({tag, "_din"}, bus.ram_din, d);
    @(negedge clk);
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
    chk({tag, "_we_off"}, {63'd0, bus.ram_we}, 64'd0);
    @(negedge clk);
    chk({tag, "_done_clr"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_done_cnt"}, done_cnt - d0, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int            lat, s, d0, w;
    logic [DW-1:0] hold;

    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_len   = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b0;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("rst_we",        {63'd0, bus.ram_we},    64'd0);
    chk("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("rst_done",      {63'd0, bus.done},      64'd0);
    chk("rst_addr",      bus.ram_addr,           64'd0);
    chk("rst_din",       bus.ram_din,            64'd0);
    chk("rst_rsp_data",  bus.rsp_data,           64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1. Write then read back
    do_write(10'h00D, 32'hFA07_F111, "t1_wr");
    do_read(10'h00D, 32'hFA07_F111, "t1_rd");

    // 2. Response held while the consumer stalls
    exp_q.push_back(32'hFA07_F111);
    drive_cmd(2'b00, 10'h00D, '0, '0);
    wait_rsp(lat);
    chk("t2_lat", lat, 64'd2);
    hold = bus.rsp_data;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid_held", {63'd0, bus.rsp_valid}, 64'd1);
      chk("t2_data_held",  bus.rsp_data,           hold);
      chk("t2_not_ready",  {63'd0, bus.req_ready}, 64'd0);
    end
    take_rsp("t2");

    // 3. Fill that wraps the top of memory
    do_write(10'h002, 32'h1234_5678, "t3_pre");
    s  = we_log.size();
    d0 = done_cnt;
    drive_cmd(2'b10, 10'h3FE, 11'd4, 32'hFFFF_BBBB);
    w = 0;
    while (!bus.done && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("t3_done_seen", {63'd0, bus.done}, 64'd1);
    chk("t3_we_cycles", we_log.size() - s, 64'd4);
    if (we_log.size() - s == 4) begin
      chk("t3_addr0", we_log[s],   64'h3FE);
      chk("t3_addr1", we_log[s+1], 64'h3FF);
      chk("t3_addr2", we_log[s+2], 64'h000);
      chk("t3_addr3", we_log[s+3], 64'h001);
    end
    @(negedge clk);
    chk("t3_done_once", done_cnt - d0, 64'd1);
    do_read(10'h000, 32'hFFFF_BBBB, "t3_rd0");
    do_read(10'h3FF, 32'hFFFF_BBBB, "t3_rd3ff");
    do_read(10'h002, 32'h1234_5678, "t3_rd2");

    // 4. Zero-length fill and reserved op complete without touching RAM
    s = we_log.size();
    drive_cmd(2'b10, 10'h055, 11'd0, 32'hDEAD_BEEF);
    chk("t4_len0_done",  {63'd0, bus.done},      64'd1);
    chk("t4_len0_ready", {63'd0, bus.req_ready}, 64'd1);
    chk("t4_len0_we",    {63'd0, bus.ram_we},    64'd0);
    @(negedge clk);
    chk("t4_len0_clr",   {63'd0, bus.done},      64'd0);
    drive_cmd(2'b11, 10'h066, 11'd5, 32'hDEAD_BEEF);
    chk("t4_rsv_done",   {63'd0, bus.done},      64'd1);
    chk("t4_rsv_ready",  {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    chk("t4_rsv_clr",    {63'd0, bus.done},      64'd0);
    chk("t4_no_writes",  we_log.size() - s,      64'd0);

    // 5. Back-to-back write then read with req_valid held
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b01;
    bus.req_addr  = 10'h010;
    bus.req_len   = '0;
    bus.req_data  = 32'hC0DE_5AA5;
    chk("t5_ready0", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    bus.req_op = 2'b00;
    chk("t5_busy", {63'd0, bus.req_ready}, 64'd0);
    @(negedge clk);
    chk("t5_done",        {63'd0, bus.done},      64'd1);
    chk("t5_ready_w_done", {63'd0, bus.req_ready}, 64'd1);
    exp_q.push_back(32'hC0DE_5AA5);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("t5_rd_taken", {63'd0, bus.req_ready}, 64'd0);
    wait_rsp(lat);
    chk("t5_lat", lat, 64'd2);
    take_rsp("t5");

    // 6. Reset in the middle of a fill
    do_write(10'h103, 32'h0BAD_0103, "t6_pre");
    s = we_log.size();
    drive_cmd(2'b10, 10'h100, 11'd8, 32'h5151_A0A0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_we",        {63'd0, bus.ram_we},    64'd0);
    chk("t6_addr",      bus.ram_addr,           64'd0);
    chk("t6_din",       bus.ram_din,            64'd0);
    chk("t6_done",      {63'd0, bus.done},      64'd0);
    chk("t6_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    chk("t6_req_ready", {63'd0, bus.req_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_words", we_log.size() - s, 64'd3);
    do_read(10'h100, 32'h5151_A0A0, "t6_rd100");
    do_read(10'h102, 32'h5151_A0A0, "t6_rd102");
    do_read(10'h103, 32'h0BAD_0103, "t6_rd103");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
